// File: rtl/tc_multi.sv
// tc_multi: NUM_CH independent prescaled down-counting timers behind one
// word-addressed register window, each with a maskable sticky interrupt.
module tc_multi #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int unsigned PRE_W = 15;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_CNT  = 2'b10;
  localparam logic [1:0] S_INT  = 2'b11;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PRESET = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  logic [27:0]       ch_off;
  logic              in_window;
  logic [1:0]        rsel;
  logic [NUM_CH-1:0] sel;
  logic [31:0]       rd_word [NUM_CH];
  logic              unused_addr_lsb;

  // Window decode: 16 bytes per channel, word index inside the channel
  assign ch_off          = addr[31:4] - BASE_ADDR[31:4];
  assign in_window       = (addr >= BASE_ADDR);
  assign rsel            = addr[3:2];
  assign unused_addr_lsb = ^addr[1:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             en, en_n;
    logic             im, im_n;
    logic             pend, pend_n;
    logic [1:0]       mode, mode_n;
    logic [1:0]       state, state_n;
    logic [3:0]       ps, ps_n;
    logic [CNT_W-1:0] preset, preset_n;
    logic [CNT_W-1:0] count, count_n;
    logic [PRE_W-1:0] pre, pre_n, pre_max;
    logic             ctrl_wr, tick;
    logic [31:0]      preset_merge;

    assign sel[i]   = in_window && (ch_off == 28'(i));
    assign ctrl_wr  = we && sel[i] && (rsel == R_CTRL) && byteen[0];
    assign pre_max  = PRE_W'((16'(1) << ps_n) - 16'(1));
    assign tick     = (pre >= pre_max);

    // Byte-merge of a PRESET write onto the current value
    always_comb begin
      preset_merge = 32'(preset);
      for (int b = 0; b < 4; b++) begin
        if (byteen[b]) preset_merge[8*b +: 8] = wdata[8*b +: 8];
      end
    end

    // Next state: the software write is applied first, then the FSM acts on it
    always_comb begin
      en_n     = en;
      mode_n   = mode;
      im_n     = im;
      ps_n     = ps;
      preset_n = preset;
      count_n  = count;
      pre_n    = pre;
      pend_n   = pend;
      state_n  = state;

      if (we && sel[i]) begin
        case (rsel)
          R_CTRL: begin
            if (byteen[0]) begin
              en_n   = wdata[0];
              mode_n = wdata[2:1];
              im_n   = wdata[3];
              ps_n   = wdata[7:4];
            end
          end
          R_PRESET: preset_n = CNT_W'(preset_merge);
          R_STATUS: if (byteen[0] && wdata[0]) pend_n = 1'b0;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (en_n) state_n = S_LOAD;
        end
        S_LOAD: begin
          if (!en_n) begin
            state_n = S_IDLE;
          end else begin
            count_n = preset;
            pre_n   = '0;
            state_n = S_CNT;
          end
        end
        S_CNT: begin
          if (!en_n) begin
            state_n = S_IDLE;
          end else if (tick) begin
            pre_n = '0;
            // A count of 0 (PRESET 0) expires like a count of 1
            if (count <= CNT_W'(1)) begin
              count_n = '0;
              state_n = S_INT;
            end else begin
              count_n = count - CNT_W'(1);
            end
          end else begin
            pre_n = pre + PRE_W'(1);
          end
        end
        default: begin
          if (!en_n) begin
            state_n = S_IDLE;
          end else begin
            pend_n = 1'b1;
            if (mode_n == 2'b01) begin
              state_n = S_LOAD;
            end else begin
              if (!ctrl_wr) en_n = 1'b0;
              state_n = S_IDLE;
            end
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en     <= 1'b0;
        mode   <= 2'b00;
        im     <= 1'b0;
        ps     <= 4'd0;
        preset <= '0;
        count  <= '0;
        pre    <= '0;
        pend   <= 1'b0;
        state  <= S_IDLE;
      end else begin
        en     <= en_n;
        mode   <= mode_n;
        im     <= im_n;
        ps     <= ps_n;
        preset <= preset_n;
        count  <= count_n;
        pre    <= pre_n;
        pend   <= pend_n;
        state  <= state_n;
      end
    end

    assign rd_word[i] = (rsel == R_CTRL)   ? {24'd0, ps, im, mode, en} :
                        (rsel == R_PRESET) ? 32'(preset) :
                        (rsel == R_COUNT)  ? 32'(count) :
                                             {29'd0, state, pend};

    assign irq[i] = pend & im;
  end

  // Read mux: unmapped addresses return 0
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) rdata = rd_word[i];
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_tc_multi.sv
// Self-checking bench for tc_multi: register-access vector table, hand-built
// corner sequences, and randomized timer runs against an arithmetic model.
module tb_tc_multi;

  localparam logic [31:0] BASE = 32'h7F00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [1:0]  irq;
  logic        irq_any;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  tc_multi #(.NUM_CH(2), .CNT_W(32), .BASE_ADDR(32'h7F00)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; we = 1'b1; byteen = be; wdata = d;
    step();
    we = 1'b0; byteen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; we = 1'b0;
    #1;
    v = rdata;
  endtask

  task automatic rchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Channel behaviour t edges after the enabling write, from period arithmetic
  function automatic void model(input int p, input int ps, input int mode, input int t,
                                output int st, output int cnt, output int pend, output int en);
    int per;
    int u;
    per  = (p == 0 ? 1 : p) << ps;
    en   = 1;
    pend = (t >= per + 2) ? 1 : 0;
    if (mode != 1 && t >= per + 2) begin
      st = 0; cnt = 0; en = 0;
    end else begin
      u = (mode == 1) ? t % (per + 2) : t;
      if (u == 0) begin
        st = 1; cnt = 0;
      end else if (u <= per) begin
        st = 2; cnt = p - ((u - 1) >> ps);
      end else begin
        st = 3; cnt = 0;
      end
    end
  endfunction

  task automatic trial(input int p0, input int ps0, input int md0, input int im0,
                       input int p1, input int ps1, input int md1, input int im1,
                       input int ncyc);
    int p [2];
    int ps [2];
    int md [2];
    int im [2];
    int start [2];
    int st, cnt, pend, en;
    logic [31:0] v;
    logic [1:0]  exp_irq;
    p[0] = p0; ps[0] = ps0; md[0] = md0; im[0] = im0;
    p[1] = p1; ps[1] = ps1; md[1] = md1; im[1] = im1;
    do_reset();
    wr(BASE + 32'd4, 4'hF, 32'(p0));
    wr(BASE + 32'd20, 4'hF, 32'(p1));
    wr(BASE, 4'hF, 32'(ps0 * 16 + im0 * 8 + md0 * 2 + 1));
    start[0] = cyc;
    wr(BASE + 32'd16, 4'hF, 32'(ps1 * 16 + im1 * 8 + md1 * 2 + 1));
    start[1] = cyc;
    for (int k = 0; k < ncyc; k++) begin
      exp_irq = '0;
      for (int c = 0; c < 2; c++) begin
        model(p[c], ps[c], md[c], cyc - start[c], st, cnt, pend, en);
        rd(BASE + 32'(16 * c + 8), v);
        chk($sformatf("ch%0d count t=%0d", c, cyc - start[c]), v, 32'(cnt));
        rd(BASE + 32'(16 * c + 12), v);
        chk($sformatf("ch%0d status t=%0d", c, cyc - start[c]), v, 32'(st * 2 + pend));
        rd(BASE + 32'(16 * c), v);
        chk($sformatf("ch%0d ctrl t=%0d", c, cyc - start[c]), v,
            32'(ps[c] * 16 + im[c] * 8 + md[c] * 2 + en));
        exp_irq[c] = (pend != 0) && (im[c] != 0);
      end
      chk($sformatf("irq k=%0d", k), 32'(irq), 32'(exp_irq));
      chk($sformatf("irq_any k=%0d", k), 32'(irq_any), 32'(|exp_irq));
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h7F04, 4'b0011, 32'hAABBCCDD, 32'h7F04, 32'h0000CCDD};
    vecs[1]  = '{1'b1, 32'h7F04, 4'b0000, 32'h11223344, 32'h7F04, 32'h0000CCDD};
    vecs[2]  = '{1'b1, 32'h7F04, 4'b1100, 32'h11223344, 32'h7F04, 32'h1122CCDD};
    vecs[3]  = '{1'b1, 32'h7F08, 4'b1111, 32'hFFFFFFFF, 32'h7F08, 32'h00000000};
    vecs[4]  = '{1'b1, 32'h7F00, 4'b1111, 32'hFFFFFFF6, 32'h7F00, 32'h000000F6};
    vecs[5]  = '{1'b1, 32'h7F00, 4'b1110, 32'h00000000, 32'h7F00, 32'h000000F6};
    vecs[6]  = '{1'b1, 32'h7F0C, 4'b1111, 32'hFFFFFFFF, 32'h7F0C, 32'h00000000};
    vecs[7]  = '{1'b1, 32'h7F20, 4'b1111, 32'h12345678, 32'h7F20, 32'h00000000};
    vecs[8]  = '{1'b1, 32'h7EFC, 4'b1111, 32'h12345678, 32'h7EFC, 32'h00000000};
    vecs[9]  = '{1'b1, 32'h7F14, 4'b1111, 32'hDEADBEEF, 32'h7F14, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 32'h0000, 4'b0000, 32'h00000000, 32'h7F04, 32'h1122CCDD};
    vecs[11] = '{1'b1, 32'h7F10, 4'b1111, 32'h000000F8, 32'h7F10, 32'h000000F8};
    vecs[12] = '{1'b1, 32'h7F00, 4'b1111, 32'h00000000, 32'h7F00, 32'h00000000};

    do_reset();
    chk("reset irq", 32'(irq), 32'h0);
    chk("reset irq_any", 32'(irq_any), 32'h0);
    rchk("reset ctrl0", BASE, 32'h0);
    rchk("reset status1", BASE + 32'd28, 32'h0);

    // Register decode, byte enables, read-only and unmapped accesses
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].be, vecs[i].wdata);
      rchk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end
    chk("vec irq", 32'(irq), 32'h0);

    // Status clear in the exact INT cycle loses to the hardware set; IM=0 masks
    do_reset();
    wr(BASE + 32'd4, 4'hF, 32'd1);
    wr(BASE, 4'hF, 32'h1);
    step();
    step();
    rchk("col int state", BASE + 32'd12, 32'h6);
    wr(BASE + 32'd12, 4'hF, 32'h1);
    rchk("col pending kept", BASE + 32'd12, 32'h1);
    chk("col masked irq", 32'(irq), 32'h0);
    wr(BASE + 32'd12, 4'hF, 32'h1);
    rchk("col cleared", BASE + 32'd12, 32'h0);

    // CTRL write during INT keeps software EN over the one-shot clear
    do_reset();
    wr(BASE + 32'd4, 4'hF, 32'd1);
    wr(BASE, 4'hF, 32'h9);
    step();
    step();
    wr(BASE, 4'hF, 32'h9);
    rchk("intwr ctrl", BASE, 32'h9);
    rchk("intwr status", BASE + 32'd12, 32'h1);
    chk("intwr irq", 32'(irq), 32'h1);
    step();
    rchk("intwr reload", BASE + 32'd12, 32'h3);

    // Software disable while in INT suppresses the pending set
    do_reset();
    wr(BASE + 32'd4, 4'hF, 32'd1);
    wr(BASE, 4'hF, 32'h9);
    step();
    step();
    wr(BASE, 4'hF, 32'h8);
    rchk("intdis status", BASE + 32'd12, 32'h0);
    chk("intdis irq", 32'(irq), 32'h0);

    // Disable mid-count holds COUNT; re-enable reloads the PRESET seen at LOAD
    do_reset();
    wr(BASE + 32'd4, 4'hF, 32'd10);
    wr(BASE, 4'hF, 32'h1);
    for (int k = 0; k < 4; k++) step();
    rchk("dis count7", BASE + 32'd8, 32'd7);
    wr(BASE, 4'hF, 32'h0);
    rchk("dis hold", BASE + 32'd8, 32'd7);
    rchk("dis idle", BASE + 32'd12, 32'h0);
    step();
    step();
    rchk("dis hold2", BASE + 32'd8, 32'd7);
    wr(BASE, 4'hF, 32'h1);
    rchk("reen load", BASE + 32'd12, 32'h2);
    rchk("reen count", BASE + 32'd8, 32'd7);
    wr(BASE + 32'd4, 4'hF, 32'd20);
    rchk("reen old preset", BASE + 32'd8, 32'd10);
    rchk("reen cnt", BASE + 32'd12, 32'h4);
    step();
    rchk("reen dec", BASE + 32'd8, 32'd9);
    rchk("reen new preset", BASE + 32'd4, 32'd20);

    // Asynchronous reset mid-count with an interrupt pending
    do_reset();
    wr(BASE + 32'd20, 4'hF, 32'd1);
    wr(BASE + 32'd16, 4'hF, 32'h9);
    wr(BASE + 32'd4, 4'hF, 32'd10);
    wr(BASE, 4'hF, 32'h1);
    for (int k = 0; k < 6; k++) step();
    rchk("pre-rst count5", BASE + 32'd8, 32'd5);
    chk("pre-rst irq", 32'(irq), 32'h2);
    #1;
    reset = 1'b0;
    #1;
    chk("rst irq", 32'(irq), 32'h0);
    chk("rst irq_any", 32'(irq_any), 32'h0);
    rchk("rst count0", BASE + 32'd8, 32'h0);
    rchk("rst status0", BASE + 32'd12, 32'h0);
    rchk("rst status1", BASE + 32'd28, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    rchk("post-rst count0", BASE + 32'd8, 32'h0);
    rchk("post-rst status0", BASE + 32'd12, 32'h0);
    rchk("post-rst ctrl0", BASE, 32'h0);
    chk("post-rst irq", 32'(irq), 32'h0);

    // One-shot PRESET=3 PS=0 alongside auto-reload PRESET=2 PS=2
    trial(3, 0, 0, 1, 2, 2, 1, 1, 50);

    for (int r = 0; r < 6; r++) begin
      trial(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 50);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
